// File: rtl/btn_debounce_edge_if.sv
// btn_debounce_edge_if: button bus between raw push-buttons and the debounce stage
// Signals:
//   i_btn         raw, asynchronous, bouncing buttons (1 = pressed)
//   o_btn_level   debounced level per button
//   o_btn_press   one-cycle pulse on an accepted press
//   o_btn_release one-cycle pulse on an accepted release
//   o_btn_toggle  inverts on every accepted press
// Modports: master drives the raw buttons and consumes the conditioned outputs;
// slave is the debouncer.
interface btn_debounce_edge_if #(
    parameter int NB_BUTTONS = 4
);
    logic [NB_BUTTONS-1:0] i_btn;
    logic [NB_BUTTONS-1:0] o_btn_level;
    logic [NB_BUTTONS-1:0] o_btn_press;
    logic [NB_BUTTONS-1:0] o_btn_release;
    logic [NB_BUTTONS-1:0] o_btn_toggle;

    modport master (
        output i_btn,
        input  o_btn_level,
        input  o_btn_press,
        input  o_btn_release,
        input  o_btn_toggle
    );

    modport slave (
        input  i_btn,
        output o_btn_level,
        output o_btn_press,
        output o_btn_release,
        output o_btn_toggle
    );
endinterface

// File: rtl/btn_debounce_edge.sv
// btn_debounce_edge: per-button synchroniser, debounce FSM and edge/toggle generation
// Ports:
//   clock    system clock, all state updates on the rising edge
//   i_reset  synchronous active-high reset
//   bus      btn_debounce_edge_if.slave: i_btn in; o_btn_level, o_btn_press,
//            o_btn_release, o_btn_toggle out (all registered)
// Each button runs an independent four-state machine. A change of the
// synchronised input is only accepted after DB_CYCLES consecutive stable
// samples; any glitch in between drops back to the stable state.
module btn_debounce_edge #(
    parameter int NB_BUTTONS = 4,
    parameter int NB_DB_CNT  = 16,
    parameter int DB_CYCLES  = 1000
) (
    input  logic                 clock,
    input  logic                 i_reset,
    btn_debounce_edge_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        PRESSED,
        CHK_REL
    } state_t;

    localparam logic [NB_DB_CNT-1:0] CNT_MAX = NB_DB_CNT'(DB_CYCLES - 1);

    logic   [NB_BUTTONS-1:0] s1_q;
    logic   [NB_BUTTONS-1:0] s2_q;
    state_t                  state_q [NB_BUTTONS];
    state_t                  state_d [NB_BUTTONS];
    logic   [NB_DB_CNT-1:0]  cnt_q   [NB_BUTTONS];
    logic   [NB_DB_CNT-1:0]  cnt_d   [NB_BUTTONS];
    logic   [NB_BUTTONS-1:0] level_q, level_d;
    logic   [NB_BUTTONS-1:0] press_q, press_d;
    logic   [NB_BUTTONS-1:0] rel_q, rel_d;
    logic   [NB_BUTTONS-1:0] tog_q, tog_d;

    // two-flop synchroniser; the FSM only ever looks at s2_q
    always_ff @(posedge clock) begin
        if (i_reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.i_btn;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            for (int i = 0; i < NB_BUTTONS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            press_q <= '0;
            rel_q   <= '0;
            tog_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            tog_q   <= tog_d;
        end
    end

    // counter is cleared on every state change, so it never exceeds CNT_MAX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = '0;
        rel_d   = '0;
        tog_d   = tog_q;
        for (int i = 0; i < NB_BUTTONS; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (s2_q[i]) begin
                        state_d[i] = CHK_PRESS;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_PRESS: begin
                    if (!s2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        press_d[i] = 1'b1;
                        tog_d[i]   = ~tog_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + NB_DB_CNT'(1);
                    end
                end
                PRESSED: begin
                    if (!s2_q[i]) begin
                        state_d[i] = CHK_REL;
                        cnt_d[i]   = '0;
                    end
                end
                CHK_REL: begin
                    if (s2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                        rel_d[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + NB_DB_CNT'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    assign bus.o_btn_level   = level_q;
    assign bus.o_btn_press   = press_q;
    assign bus.o_btn_release = rel_q;
    assign bus.o_btn_toggle  = tog_q;
endmodule

// File: doc/btn_debounce_edge.md
Name: btn_debounce_edge

Overview:
Upstream conditioning stage for the board push-buttons that feed the LED mode/colour control top (top_ej2) on its i_btn input. Each raw button is synchronised, debounced by a per-button state machine and counter, and presented downstream as four signals: a clean level, a one-cycle press pulse, a one-cycle release pulse and a press-toggled latch. Buttons are fully independent; all logic runs on the single system clock.

Parameters:
NB_BUTTONS, 4, number of independent button channels
NB_DB_CNT, 16, width of each per-button debounce counter; must hold DB_CYCLES-1
DB_CYCLES, 1000, consecutive stable synchronised samples needed to accept a change; legal range 2..2^NB_DB_CNT

Ports:
clock  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_btn  input  NB_BUTTONS  raw, asynchronous, bouncing button inputs; 1 = pressed
o_btn_level  output  NB_BUTTONS  debounced level per button
o_btn_press  output  NB_BUTTONS  one-cycle pulse when a press is accepted
o_btn_release  output  NB_BUTTONS  one-cycle pulse when a release is accepted
o_btn_toggle  output  NB_BUTTONS  inverts on every accepted press

Behaviour:
- Reset: i_reset sampled high at a rising edge clears, for every bit:
  - synchroniser flops = 0
  - FSM = IDLE
  - counter = 0
  - all outputs = 0
  Reset overrides everything, including mid-count and during a pulse.
- Synchroniser: two flops per bit, i_btn -> s1 -> s2. The FSM sees only s2.
- Per-button FSM, four states:
  - IDLE (level 0): if s2 = 1, go to CHK_PRESS and set cnt = 0; otherwise stay.
  - CHK_PRESS (level 0):
    - s2 = 0: return to IDLE and set cnt = 0 (bounce rejected, no pulse).
    - s2 = 1 and cnt = DB_CYCLES-1: go to PRESSED.
    - s2 = 1 otherwise: cnt = cnt + 1.
  - PRESSED (level 1): if s2 = 0, go to CHK_REL and set cnt = 0.
  - CHK_REL (level 1):
    - s2 = 1: return to PRESSED and set cnt = 0.
    - s2 = 0 and cnt = DB_CYCLES-1: go to IDLE.
    - s2 = 0 otherwise: cnt = cnt + 1.
- Outputs are registered and updated on the same edge as the FSM transition:
  - CHK_PRESS -> PRESSED: o_btn_level <= 1, o_btn_press <= 1 for exactly one cycle, o_btn_toggle <= ~o_btn_toggle.
  - CHK_REL -> IDLE: o_btn_level <= 0, o_btn_release <= 1 for exactly one cycle.
- Latency: let E0 be the first edge that samples raw = 1, with raw held high through E0+DB_CYCLES.
  - s2 = 1 after E1.
  - CHK_PRESS entered at E2.
  - Press accepted at E(DB_CYCLES+2): level and press pulse are visible after that edge.
  - Release latency is symmetric.
- Counter never wraps: max value DB_CYCLES-1, cleared on every state entry.
- Button held through reset: after reset deasserts, s2 rises and a full debounce runs, giving a fresh press pulse. The pre-reset state is not remembered.
- Simultaneous activity on several buttons: independent channels; multiple press bits may be high in the same cycle.
- A press pulse is never followed by another press pulse without an intervening release pulse.

Test Plan:
- Reset with i_btn = 4'b1111 held -> all outputs 0 while reset is high. Release reset with DB_CYCLES = 4 -> o_btn_press = 4'b1111 for one cycle, 6 edges after the first sampling edge; o_btn_level = 4'b1111; o_btn_toggle = 4'b1111.
- DB_CYCLES = 4; i_btn[0] high 3 cycles, low 2, then held high -> no pulse from the first burst. Exactly one o_btn_press[0] pulse at E0+6 measured from the start of the final high; o_btn_level[0] = 1.
- Release i_btn[0] with a 2-cycle rebound high in the middle -> one o_btn_release[0] pulse only after 4 stable low samples; level falls on the same edge.
- Press/release i_btn[1] three times -> o_btn_toggle[1] sequence 1, 0, 1; 3 press and 3 release pulses, each one cycle wide.
- i_btn = 4'b0011 applied on one edge -> o_btn_press = 4'b0011 in the same cycle. Then drop only bit 0 -> o_btn_release = 4'b0001 and o_btn_level = 4'b0010.
- Assert i_reset mid-CHK_PRESS (cnt = 2) and on the cycle a press pulse is high -> all outputs 0 on the next edge; no pulse emitted during reset.
